count_bank: RTL and testbench

Parametrised bank of independent up/down counters; next generation of the single fixed-width counter in `parts/count.v`. Width, channel count, terminal value and overflow mode are set at elaboration. Adds per-channel load, sticky overflow/underflow flags, terminal-count pulses, and a registered valid/ready readout port. Sits beside event sources (e.g. per-lane strobes) and is polled by a control/status block.

---
 rtl/count_bank_pkg.sv | 20 ++
 rtl/count_bank_cell.sv | 87 ++++++++
 rtl/count_bank.sv | 107 ++++++++++
 tb/tb_count_bank.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_bank_pkg.sv
// Shared types and constants for the counter bank and its cells.
package count_bank_pkg;

    // Overflow handling at the count limits.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    // Readout handshake states.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_e;

    // Bit positions inside the two-bit flag word returned by a readout.
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

endpackage

// File: rtl/count_bank_cell.sv
// One up/down counter with load, sticky overflow/underflow and terminal-count pulse.
module count_cell
    import count_bank_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 255,
    parameter count_mode_e MODE      = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Next state: clear beats load beats a single-direction strobe; opposing strobes cancel.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (inc && !dec) begin
            if (count_q == MAX_V) begin
                ovf_d = 1'b1;
                if (MODE == MODE_WRAP) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end
            end else begin
                count_d = count_q + ONE_V;
                // In saturating mode the terminal pulse marks arrival at the limit.
                tc_d    = (MODE == MODE_SAT) && ((count_q + ONE_V) == MAX_V);
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                unf_d = 1'b1;
                if (MODE == MODE_WRAP) begin
                    count_d = MAX_V;
                    tc_d    = 1'b1;
                end
            end else begin
                count_d = count_q - ONE_V;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/count_bank.sv
// Bank of independent counters with a registered valid/ready snapshot readout.
module count_bank
    import count_bank_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          CHANNELS  = 4,
    parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
    parameter count_mode_e MODE      = MODE_WRAP,
    localparam int         CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [CHANNELS-1:0] inc,
    input  logic [CHANNELS-1:0] dec,
    input  logic                load_en,
    input  logic [CW-1:0]       load_ch,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                rd_req,
    input  logic [CW-1:0]       rd_ch,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WIDTH-1:0]    rd_data,
    output logic [1:0]          rd_flags,
    output logic [CHANNELS-1:0] tc,
    output logic [CHANNELS-1:0] ovf,
    output logic [CHANNELS-1:0] unf
);

    logic [WIDTH-1:0] count_w [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cell
            count_cell #(
                .WIDTH     (WIDTH),
                .MAX_COUNT (MAX_COUNT),
                .MODE      (MODE)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .inc      (inc[gi]),
                .dec      (dec[gi]),
                .load     (load_en && (load_ch == CW'(gi))),
                .load_val (load_val),
                .count    (count_w[gi]),
                .tc       (tc[gi]),
                .ovf      (ovf[gi]),
                .unf      (unf[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0] sel_count;
    logic [1:0]       sel_flags;

    // Channel select for the snapshot; an unmatched (out-of-range) channel reads as zero.
    always_comb begin
        sel_count = '0;
        sel_flags = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) begin
                sel_count           = count_w[i];
                sel_flags[FLAG_OVF] = ovf[i];
                sel_flags[FLAG_UNF] = unf[i];
            end
        end
    end

    rd_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       flags_q, flags_d;
    logic             accept;

    // Readout FSM: a request is taken only when the output slot is free or being drained.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        flags_d = flags_q;
        accept  = rd_req && ((state_q == RD_IDLE) || rd_ready);
        if (accept) begin
            state_d = RD_HOLD;
            data_d  = sel_count;
            flags_d = sel_flags;
        end else if ((state_q == RD_HOLD) && rd_ready) begin
            state_d = RD_IDLE;
        end
    end

    // Readout state and snapshot registers; clr deliberately leaves a held snapshot alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            flags_q <= flags_d;
        end
    end

    assign rd_valid = (state_q == RD_HOLD);
    assign rd_data  = data_q;
    assign rd_flags = flags_q;

endmodule

// File: tb/tb_count_bank.sv
// Bench: one wrapping and one saturating bank driven by the same directed stimulus.
module tb_count_bank;
    import count_bank_pkg::*;

    localparam int W  = 8;
    localparam int CH = 3;
    localparam int CW = 2;
    localparam int MAXC [2] = '{9, 255};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1, clr = 1'b0, load_en = 1'b0, rd_req = 1'b0, rd_ready = 1'b0;
    logic [CH-1:0] inc = '0, dec = '0;
    logic [CW-1:0] load_ch = '0, rd_ch = '0;
    logic [W-1:0]  load_val = '0;

    logic          rv_w, rv_s;
    logic [W-1:0]  rd_w, rd_s;
    logic [1:0]    rf_w, rf_s;
    logic [CH-1:0] tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;

    count_bank #(.WIDTH(W), .CHANNELS(CH), .MAX_COUNT(9), .MODE(MODE_WRAP)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .dec(dec),
        .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rv_w), .rd_ready(rd_ready),
        .rd_data(rd_w), .rd_flags(rf_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w));

    count_bank #(.WIDTH(W), .CHANNELS(CH), .MAX_COUNT(255), .MODE(MODE_SAT)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .dec(dec),
        .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rv_s), .rd_ready(rd_ready),
        .rd_data(rd_s), .rd_flags(rf_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s));

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model; index 0 = wrapping bank, 1 = saturating bank.
    int          m_cnt [2][CH];
    bit [CH-1:0] m_tc [2], m_ovf [2], m_unf [2];
    bit          m_rv [2];
    bit [W-1:0]  m_rd [2];
    bit [1:0]    m_rf [2];

    int          n_cnt [2][CH];
    bit [CH-1:0] n_tc [2], n_ovf [2], n_unf [2];
    bit          n_rv [2];
    bit [W-1:0]  n_rd [2];
    bit [1:0]    n_rf [2];

    always_comb begin
        n_cnt = m_cnt;
        n_tc  = '{default: '0};
        n_ovf = m_ovf;
        n_unf = m_unf;
        n_rv  = m_rv;
        n_rd  = m_rd;
        n_rf  = m_rf;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (clr) begin
                    n_cnt[d][c] = 0;
                    n_ovf[d][c] = 1'b0;
                    n_unf[d][c] = 1'b0;
                end else if (load_en && int'(load_ch) == c) begin
                    n_cnt[d][c] = (int'(load_val) > MAXC[d]) ? MAXC[d] : int'(load_val);
                end else if (inc[c] && !dec[c]) begin
                    if (m_cnt[d][c] == MAXC[d]) begin
                        n_ovf[d][c] = 1'b1;
                        if (d == 0) begin
                            n_cnt[d][c] = 0;
                            n_tc[d][c]  = 1'b1;
                        end
                    end else begin
                        n_cnt[d][c] = m_cnt[d][c] + 1;
                        n_tc[d][c]  = (d == 1) && (m_cnt[d][c] + 1 == MAXC[d]);
                    end
                end else if (dec[c] && !inc[c]) begin
                    if (m_cnt[d][c] == 0) begin
                        n_unf[d][c] = 1'b1;
                        if (d == 0) begin
                            n_cnt[d][c] = MAXC[d];
                            n_tc[d][c]  = 1'b1;
                        end
                    end else begin
                        n_cnt[d][c] = m_cnt[d][c] - 1;
                    end
                end
            end
            if (rd_req && (!m_rv[d] || rd_ready)) begin
                n_rv[d] = 1'b1;
                n_rd[d] = '0;
                n_rf[d] = '0;
                if (int'(rd_ch) < CH) begin
                    n_rd[d] = W'(m_cnt[d][rd_ch]);
                    n_rf[d] = {m_ovf[d][rd_ch], m_unf[d][rd_ch]};
                end
            end else if (rd_ready) begin
                n_rv[d] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '{default: '{default: 0}};
            m_tc  <= '{default: '0};
            m_ovf <= '{default: '0};
            m_unf <= '{default: '0};
            m_rv  <= '{default: 1'b0};
            m_rd  <= '{default: '0};
            m_rf  <= '{default: '0};
        end else begin
            m_cnt <= n_cnt;
            m_tc  <= n_tc;
            m_ovf <= n_ovf;
            m_unf <= n_unf;
            m_rv  <= n_rv;
            m_rd  <= n_rd;
            m_rf  <= n_rf;
        end
    end

    // Per-cycle comparison of both banks against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("w_tc", tc_w, m_tc[0]);   chk("s_tc", tc_s, m_tc[1]);
            chk("w_ovf", ovf_w, m_ovf[0]); chk("s_ovf", ovf_s, m_ovf[1]);
            chk("w_unf", unf_w, m_unf[0]); chk("s_unf", unf_s, m_unf[1]);
            chk("w_rv", rv_w, m_rv[0]);   chk("s_rv", rv_s, m_rv[1]);
            chk("w_rd", rd_w, m_rd[0]);   chk("s_rd", rd_s, m_rd[1]);
            chk("w_rf", rf_w, m_rf[0]);   chk("s_rf", rf_s, m_rf[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle request with the consumer ready; leaves rd_ready high.
    task automatic rd(input int ch);
        rd_ch    = CW'(ch);
        rd_req   = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_req   = 1'b0;
        $display("read ch%0d: w=%0d/%b s=%0d/%b", ch, rd_w, rf_w, rd_s, rf_s);
    endtask

    int tcp;

    initial begin
        #2 rst_n = 1'b0;
        tick(); tick();
        cmp_en = 1'b1;
        chk("reset_rv", rv_w, 0);
        chk("reset_rd", rd_w, 0);
        chk("reset_tc", tc_w, 0);
        chk("reset_ovf", ovf_w, 0);
        chk("reset_unf", unf_s, 0);
        rst_n = 1'b1;
        tick();

        // Wrap at MAX_COUNT=9; the read on the wrapping edge sees the pre-update value.
        inc[0] = 1'b1;
        tcp = 0;
        repeat (9) begin tick(); tcp += int'(tc_w[0]); end
        rd(0);
        tcp += int'(tc_w[0]);
        inc[0] = 1'b0;
        chk("wrap_snap9", rd_w, 9);
        chk("wrap_snapflags", rf_w, 2'b00);
        chk("wrap_ovf", ovf_w[0], 1);
        chk("sat_nowrap", rd_s, 9);
        rd(0);
        tcp += int'(tc_w[0]);
        chk("wrap_to0", rd_w, 0);
        chk("wrap_flags", rf_w, 2'b10);
        chk("wrap_tc_once", tcp, 1);
        tick();
        chk("rd_drop", rv_w, 0);

        // Saturation at 255, load clamp on the 9-limit bank.
        load_en = 1'b1; load_ch = 2'd0; load_val = 8'd254;
        tick();
        load_en = 1'b0;
        inc[0] = 1'b1;
        tcp = 0;
        repeat (3) begin tick(); tcp += int'(tc_s[0]); end
        inc[0] = 1'b0;
        chk("sat_tc_once", tcp, 1);
        chk("sat_ovf", ovf_s[0], 1);
        rd(0);
        chk("sat_hold255", rd_s, 255);
        chk("clamp_then_wrap", rd_w, 2);
        tick();
        load_en = 1'b1; load_val = 8'd0;
        tick();
        load_en = 1'b0;
        dec[0] = 1'b1;
        tick();
        dec[0] = 1'b0;
        chk("sat_unf", unf_s[0], 1);
        chk("sat_unf_notc", tc_s[0], 0);
        chk("wrap_unf_tc", tc_w[0], 1);
        rd(0);
        chk("sat_hold0", rd_s, 0);
        tick();

        // Load beats simultaneous inc/dec; inc+dec alone is a no-op.
        load_en = 1'b1; load_ch = 2'd1; load_val = 8'd7; inc[1] = 1'b1; dec[1] = 1'b1;
        tick();
        load_en = 1'b0;
        tick();
        inc[1] = 1'b0; dec[1] = 1'b0;
        chk("incdec_notc", tc_w[1], 0);
        rd(1);
        chk("load7_w", rd_w, 7);
        chk("load7_s", rd_s, 7);
        tick();

        // Held readout with back-pressure, ignored second request, clr during hold.
        inc[2] = 1'b1;
        repeat (5) tick();
        inc[2] = 1'b0;
        rd_ch = 2'd2; rd_req = 1'b1; rd_ready = 1'b0;
        tick();
        chk("hold_valid", rv_w, 1);
        chk("hold_data", rd_w, 5);
        rd_ch = 2'd1; inc[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clr = (k == 1);
            tick();
            clr = 1'b0;
            chk("hold_stable_w", rd_w, 5);
            chk("hold_stable_s", rd_s, 5);
            chk("hold_valid_k", rv_w, 1);
        end
        inc[2] = 1'b0;
        chk("clr_ovf", ovf_w, 0);
        chk("clr_unf", unf_s, 0);
        rd_req = 1'b0; rd_ready = 1'b1;
        tick();
        chk("hold_release", rv_w, 0);

        // Out-of-range load and read channels.
        dec[0] = 1'b1;
        tick();
        dec[0] = 1'b0;
        load_en = 1'b1; load_ch = 2'd3; load_val = 8'd4;
        tick();
        load_en = 1'b0;
        rd(3);
        chk("oor_valid", rv_w, 1);
        chk("oor_data", rd_w, 0);
        chk("oor_flags", rf_s, 2'b00);
        tick();
        rd(0);
        chk("oor_noload_w", rd_w, 9);
        chk("oor_noload_s", rd_s, 0);
        chk("oor_ch0flags", rf_s, 2'b01);
        tick();

        // Asynchronous reset mid-count and mid-hold.
        inc = 3'b111;
        repeat (3) tick();
        rd_ch = 2'd0; rd_req = 1'b1; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("pre_rst_valid", rv_w, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rv_w", rv_w, 0);  chk("arst_rv_s", rv_s, 0);
        chk("arst_rd_w", rd_w, 0);  chk("arst_rd_s", rd_s, 0);
        chk("arst_rf", {rf_w, rf_s}, 0);
        chk("arst_tc", {tc_w, tc_s}, 0);
        chk("arst_ovf", {ovf_w, ovf_s}, 0);
        chk("arst_unf", {unf_w, unf_s}, 0);
        tick(); tick();
        inc = '0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_rv", rv_w, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
